// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - fully associative branch target buffer with saturating direction counters
//
// Purpose: FETCH looks up f_pc against all valid tags and returns a registered
// target/taken prediction one cycle later. DECODE allocates newly seen branches
// (lowest invalid entry first, otherwise round-robin). EXEC trains the entry
// whose tag matches the resolved branch PC.
//
// Optional feature: define BP_PERF_COUNTERS_EN to add lookup/hit/mispredict counters.
//
// Ports:
//   clk              clock, all state updates on rising edge
//   reset            asynchronous active-high reset
//   f_pc             FETCH lookup address
//   f_predict_addr   registered predicted target (0 on miss)
//   f_predict_valid  registered hit-and-predict-taken
//   d_is_branch      DECODE instruction is a branch
//   d_pc             PC of decoded branch
//   d_target_addr    decoded branch target
//   x_valid          EXEC resolution valid
//   x_pc             PC of resolved branch
//   x_taken          branch actually taken
//   x_target_addr    resolved target
//   perf_lookups     (BP_PERF_COUNTERS_EN) cycles counted, saturating
//   perf_hits        (BP_PERF_COUNTERS_EN) FETCH hits, saturating
//   perf_mispredicts (BP_PERF_COUNTERS_EN) direction/target mispredicts, saturating
module branch_target_buffer #(
  parameter int ENTRIES  = 8,
  parameter int ADDR_W   = 32,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] f_predict_addr,
  output logic              f_predict_valid,
  input  logic              d_is_branch,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [ADDR_W-1:0] d_target_addr,
  input  logic              x_valid,
  input  logic [ADDR_W-1:0] x_pc,
  input  logic              x_taken,
  input  logic [ADDR_W-1:0] x_target_addr
`ifdef BP_PERF_COUNTERS_EN
  ,
  output logic [31:0]       perf_lookups,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_mispredicts
`endif
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  logic [ADDR_W-1:0] tag_q [ENTRIES];
  logic [ADDR_W-1:0] tgt_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [IDX_W-1:0]   ptr_q;

  logic             f_hit, d_hit, x_hit, free_any;
  logic [IDX_W-1:0] f_idx, x_idx, free_idx, victim;
  logic             alloc_en, train_en;

  // Tag match on all ports; the free-slot scan runs high-to-low so the
  // lowest invalid index is the one left standing.
  always_comb begin
    f_hit    = 1'b0;
    f_idx    = '0;
    d_hit    = 1'b0;
    x_hit    = 1'b0;
    x_idx    = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (valid_q[i] && tag_q[i] == f_pc) begin
        f_hit = 1'b1;
        f_idx = IDX_W'(i);
      end
      if (valid_q[i] && tag_q[i] == d_pc) begin
        d_hit = 1'b1;
      end
      if (valid_q[i] && tag_q[i] == x_pc) begin
        x_hit = 1'b1;
        x_idx = IDX_W'(i);
      end
    end
  end

  assign victim   = free_any ? free_idx : ptr_q;
  assign alloc_en = d_is_branch && !d_hit;
  // Allocation owns the victim entry this cycle; training it would corrupt
  // the freshly installed branch.
  assign train_en = x_valid && x_hit && !(alloc_en && victim == x_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q         <= '0;
      ptr_q           <= '0;
      f_predict_addr  <= '0;
      f_predict_valid <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else begin
      f_predict_addr  <= f_hit ? tgt_q[f_idx] : '0;
      f_predict_valid <= f_hit && ctr_q[f_idx][CTR_W-1];
      if (train_en) begin
        if (x_taken) begin
          if (ctr_q[x_idx] != CTR_MAX) ctr_q[x_idx] <= ctr_q[x_idx] + 1'b1;
        end else begin
          if (ctr_q[x_idx] != '0) ctr_q[x_idx] <= ctr_q[x_idx] - 1'b1;
        end
      end
      if (alloc_en) begin
        valid_q[victim] <= 1'b1;
        ctr_q[victim]   <= CTR_INIT;
        if (!free_any) ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  // Tags and targets carry no reset: an entry is ignored until its valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      tag_q[victim] <= d_pc;
      tgt_q[victim] <= d_target_addr;
    end
    if (train_en && x_taken) tgt_q[x_idx] <= x_target_addr;
  end

`ifdef BP_PERF_COUNTERS_EN
  logic pred_dir, mispredict;
  // A miss predicts not-taken; a taken prediction also needs the right target.
  assign pred_dir   = x_hit && ctr_q[x_idx][CTR_W-1];
  assign mispredict = x_valid && ((pred_dir != x_taken) ||
                                  (pred_dir && tgt_q[x_idx] != x_target_addr));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lookups     <= '0;
      perf_hits        <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (perf_lookups != '1) perf_lookups <= perf_lookups + 1'b1;
      if (f_hit && perf_hits != '1) perf_hits <= perf_hits + 1'b1;
      if (mispredict && perf_mispredicts != '1) perf_mispredicts <= perf_mispredicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_pc;
  logic [31:0] f_predict_addr;
  logic        f_predict_valid;
  logic        d_is_branch;
  logic [31:0] d_pc;
  logic [31:0] d_target_addr;
  logic        x_valid;
  logic [31:0] x_pc;
  logic        x_taken;
  logic [31:0] x_target_addr;
`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] perf_lookups, perf_hits, perf_mispredicts;
`endif

  int passed = 0;
  int total  = 0;

  branch_target_buffer #(.ENTRIES(8), .ADDR_W(32), .CTR_W(2), .INIT_CTR(1)) dut (
    .clk(clk), .reset(reset),
    .f_pc(f_pc), .f_predict_addr(f_predict_addr), .f_predict_valid(f_predict_valid),
    .d_is_branch(d_is_branch), .d_pc(d_pc), .d_target_addr(d_target_addr),
    .x_valid(x_valid), .x_pc(x_pc), .x_taken(x_taken), .x_target_addr(x_target_addr)
`ifdef BP_PERF_COUNTERS_EN
    , .perf_lookups(perf_lookups), .perf_hits(perf_hits), .perf_mispredicts(perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One rising edge with the current inputs, then settle on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    d_is_branch = 1'b0; d_pc = '0; d_target_addr = '0;
    x_valid = 1'b0; x_pc = '0; x_taken = 1'b0; x_target_addr = '0;
  endtask

  task automatic do_reset();
    idle();
    f_pc  = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [31:0] tgt);
    d_is_branch = 1'b1; d_pc = pc; d_target_addr = tgt;
    step();
    d_is_branch = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    x_valid = 1'b1; x_pc = pc; x_taken = tk; x_target_addr = tgt;
    step();
    x_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic [31:0] exp_addr, input logic exp_valid);
    f_pc = pc;
    step();
    chk({tag, "_addr"}, f_predict_addr, exp_addr);
    chk({tag, "_valid"}, {31'd0, f_predict_valid}, {31'd0, exp_valid});
  endtask

  initial begin
    idle();
    f_pc  = '0;
    reset = 1'b1;
    #1;
    chk("rst_addr", f_predict_addr, 32'h0);
    chk("rst_valid", {31'd0, f_predict_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Empty buffer misses.
    for (int i = 0; i < 3; i++) look("empty_0x100", 32'h100, 32'h0, 1'b0);

    // Allocate then train; the allocating edge's lookup still misses.
    f_pc = 32'h100;
    alloc(32'h100, 32'h200);
    chk("same_cycle_alloc_invisible", {31'd0, f_predict_valid}, 32'h0);
    chk("same_cycle_alloc_addr", f_predict_addr, 32'h0);
    look("ctr1", 32'h100, 32'h200, 1'b0);
    train(32'h100, 1'b1, 32'h200);
    look("ctr2", 32'h100, 32'h200, 1'b1);
    train(32'h100, 1'b0, 32'h200);
    train(32'h100, 1'b0, 32'h200);
    look("ctr0", 32'h100, 32'h200, 1'b0);
    train(32'h100, 1'b0, 32'h200);
    train(32'h100, 1'b1, 32'h200);
    look("sat_low_then_taken", 32'h100, 32'h200, 1'b0);

    // Fill all entries then replace round-robin.
    do_reset();
    for (int i = 0; i < 10; i++) alloc(32'(i * 4), 32'(32'h1000 + i * 4));
    look("evicted_0x0", 32'h0, 32'h0, 1'b0);
    look("evicted_0x4", 32'h4, 32'h0, 1'b0);
    look("kept_0x8", 32'h8, 32'h1008, 1'b0);
    look("new_0x20", 32'h20, 32'h1020, 1'b0);
    look("new_0x24", 32'h24, 32'h1024, 1'b0);
    alloc(32'h8, 32'h5555);
    look("dup_alloc_ignored", 32'h8, 32'h1008, 1'b0);
    alloc(32'h28, 32'h1028);
    look("ptr_victim2_0x8", 32'h8, 32'h0, 1'b0);
    look("ptr_kept_0xc", 32'hC, 32'h100C, 1'b0);
    look("ptr_new_0x28", 32'h28, 32'h1028, 1'b0);

    // Saturation at the top and target retraining.
    do_reset();
    alloc(32'h40, 32'h80);
    train(32'h40, 1'b1, 32'h80);
    train(32'h40, 1'b1, 32'h80);
    train(32'h40, 1'b1, 32'h90);
    look("sat_high_target", 32'h40, 32'h90, 1'b1);
    train(32'h40, 1'b0, 32'h0);
    look("sat_high_then_nt", 32'h40, 32'h90, 1'b1);

    // Allocation and training collide on the same entry.
    do_reset();
    for (int i = 0; i < 8; i++) alloc(32'(32'h500 + i * 4), 32'(32'h600 + i * 4));
    train(32'h500, 1'b1, 32'h600);
    look("pre_collide", 32'h500, 32'h600, 1'b1);
    d_is_branch = 1'b1; d_pc = 32'h300; d_target_addr = 32'h700;
    x_valid = 1'b1; x_pc = 32'h500; x_taken = 1'b1; x_target_addr = 32'h999;
    step();
    idle();
    look("collide_new", 32'h300, 32'h700, 1'b0);
    look("collide_old", 32'h500, 32'h0, 1'b0);
    d_is_branch = 1'b1; d_pc = 32'h304; d_target_addr = 32'h704;
    x_valid = 1'b1; x_pc = 32'h304; x_taken = 1'b1; x_target_addr = 32'h888;
    step();
    idle();
    look("dx_same_pc", 32'h304, 32'h704, 1'b0);
    look("dx_victim1_gone", 32'h504, 32'h0, 1'b0);

`ifdef BP_PERF_COUNTERS_EN
    do_reset();
    f_pc = 32'h0;
    alloc(32'hA0, 32'hB0);
    f_pc = 32'hA0;
    train(32'hA0, 1'b1, 32'hB0);
    train(32'hA0, 1'b1, 32'hB0);
    train(32'hC0, 1'b0, 32'h0);
    step();
    f_pc = 32'h0;
    for (int i = 0; i < 5; i++) step();
    chk("perf_lookups", perf_lookups, 32'd10);
    chk("perf_hits", perf_hits, 32'd4);
    chk("perf_mispredicts", perf_mispredicts, 32'd1);
    reset = 1'b1;
    #1;
    chk("perf_lookups_rst", perf_lookups, 32'd0);
    chk("perf_hits_rst", perf_hits, 32'd0);
    chk("perf_mispredicts_rst", perf_mispredicts, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
